tcam_lookup_ctrl: RTL and testbench

TCAM_LOOKUP_CTRL -- requirements
Module: tcam_lookup_ctrl

---
 rtl/tcam_pkg.sv | 39 +++
 rtl/tcam_lookup_ctrl_if.sv | 41 ++++
 rtl/tcam_hit_enc.sv | 39 +++
 rtl/tcam_lookup_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_tcam_lookup_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM lookup controller.
// A TCAM word packs the lookup key in the upper half and the destination ID
// in the lower half.
package tcam_pkg;

  localparam int ID_W       = 4;
  localparam int BITS       = 8;
  localparam int WORDS      = 16;
  localparam int ADDR_W     = 4;
  localparam int STARVE_MAX = 4;

  // Field positions inside a TCAM word
  localparam int KEY_LSB = ID_W;
  localparam int DST_LSB = 0;

  // Compare mask that enables the key field and ignores the destination field
  localparam logic [BITS-1:0] KEY_ONLY_MSKB = {{ID_W{1'b1}}, {ID_W{1'b0}}};

  typedef enum logic [2:0] {
    INIT_FLUSH,
    IDLE,
    WRITE,
    FLUSH,
    CMP,
    RD,
    RESP
  } state_t;

  // Build a TCAM word from its key and destination fields
  function automatic logic [BITS-1:0] pack_word(input logic [ID_W-1:0] key,
                                                input logic [ID_W-1:0] dst);
    logic [BITS-1:0] w;
    w = '0;
    w[KEY_LSB +: ID_W] = key;
    w[DST_LSB +: ID_W] = dst;
    return w;
  endfunction

endpackage

// File: rtl/tcam_lookup_ctrl_if.sv
// Requester-side bus of the TCAM lookup controller: entry writes, flush
// requests, lookup requests and lookup results.
interface tcam_lookup_ctrl_if
  import tcam_pkg::*;
#(
  parameter int ID_W   = tcam_pkg::ID_W,
  parameter int BITS   = tcam_pkg::BITS,
  parameter int ADDR_W = tcam_pkg::ADDR_W
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [ID_W-1:0]   cfg_key;
  logic [ID_W-1:0]   cfg_dst;
  logic [BITS-1:0]   cfg_mask;
  logic              flush_req;
  logic              lkp_valid;
  logic              lkp_ready;
  logic [ID_W-1:0]   lkp_id;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [ID_W-1:0]   res_dst;
  logic [ADDR_W-1:0] res_addr;

  // Requester side
  modport master (
    output cfg_valid, cfg_addr, cfg_key, cfg_dst, cfg_mask, flush_req,
           lkp_valid, lkp_id, res_ready,
    input  cfg_ready, lkp_ready, res_valid, res_hit, res_dst, res_addr
  );

  // Controller side
  modport slave (
    input  cfg_valid, cfg_addr, cfg_key, cfg_dst, cfg_mask, flush_req,
           lkp_valid, lkp_id, res_ready,
    output cfg_ready, lkp_ready, res_valid, res_hit, res_dst, res_addr
  );

endinterface

// File: rtl/tcam_hit_enc.sv
// Priority encoder for the TCAM match lines: the lowest-index set bit wins.
module tcam_hit_enc
  import tcam_pkg::*;
#(
  parameter int WORDS  = tcam_pkg::WORDS,
  parameter int ADDR_W = tcam_pkg::ADDR_W
) (
  input  logic [WORDS-1:0]  hitline,
  output logic [ADDR_W-1:0] hit_addr,
  output logic              hit_any
);

  logic [WORDS-1:0] first_hit;

  // A word is the winner when it matches and no lower word matches
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first_hit[gi] = hitline[gi];
      end else begin : g_upper
        assign first_hit[gi] = hitline[gi] & ~(|hitline[gi-1:0]);
      end
    end
  endgenerate

  // One-hot winner to binary address
  always_comb begin
    hit_addr = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (first_hit[i]) begin
        hit_addr = hit_addr | ADDR_W'(i);
      end
    end
  end

  assign hit_any = |hitline;

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// TCAM lookup controller: arbitrates entry writes, table flushes and key
// lookups onto a single TCAM macro, tracks which entries are valid, and
// returns one result per lookup (hit flag, destination, matching entry).
module tcam_lookup_ctrl
  import tcam_pkg::*;
#(
  parameter int ID_W       = tcam_pkg::ID_W,
  parameter int BITS       = tcam_pkg::BITS,
  parameter int WORDS      = tcam_pkg::WORDS,
  parameter int ADDR_W     = tcam_pkg::ADDR_W,
  parameter int STARVE_MAX = tcam_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  tcam_lookup_ctrl_if.slave bus,
  output logic [ADDR_W:0]   entry_cnt,
  output logic              table_full,
  output logic              tcam_cs,
  output logic              tcam_flush,
  output logic              tcam_wr,
  output logic              tcam_cmp,
  output logic              tcam_rd,
  output logic              tcam_vbe,
  output logic              tcam_vbi,
  output logic              tcam_dcs,
  output logic [BITS-1:0]   tcam_di,
  output logic [BITS-1:0]   tcam_mskb,
  output logic [ADDR_W-1:0] tcam_a,
  output logic              tcam_cbe,
  input  logic [BITS-1:0]   tcam_do,
  input  logic              tcam_hit,
  input  logic [WORDS-1:0]  tcam_hitline
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0]  STV_MAX = STV_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_t            state_reg;
  logic              cmp_eval_reg;   // second CMP cycle: macro match result is valid
  logic [STV_W-1:0]  starve_reg;
  logic              flush_pend_reg;
  logic [WORDS-1:0]  valid_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ID_W-1:0]   wr_key_reg;
  logic [ID_W-1:0]   wr_dst_reg;
  logic [BITS-1:0]   wr_mask_reg;
  logic [ID_W-1:0]   lkp_id_reg;
  logic              res_valid_reg;
  logic              res_hit_reg;
  logic [ID_W-1:0]   res_dst_reg;
  logic [ADDR_W-1:0] res_addr_reg;

  logic              grant_flush;
  logic              grant_wr;
  logic              grant_lkp;
  logic [ADDR_W-1:0] enc_addr;
  logic              unused_enc_any;
  logic              unused_do_key;

  tcam_hit_enc #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_hit_enc (
    .hitline  (tcam_hitline),
    .hit_addr (enc_addr),
    .hit_any  (unused_enc_any)
  );

  // The key half of the read word is not needed; only the destination is returned
  assign unused_do_key = ^tcam_do[KEY_LSB +: ID_W];

  // IDLE arbitration: flush first, then write, unless a waiting lookup has been starved
  always_comb begin
    grant_flush = 1'b0;
    grant_wr    = 1'b0;
    grant_lkp   = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (flush_pend_reg || bus.flush_req) begin
        grant_flush = 1'b1;
      end else if (bus.cfg_valid && !(bus.lkp_valid && starve_reg == STV_MAX)) begin
        grant_wr = 1'b1;
      end else if (bus.lkp_valid) begin
        grant_lkp = 1'b1;
      end
    end
  end

  assign bus.cfg_ready = grant_wr;
  assign bus.lkp_ready = grant_lkp;

  // Main sequencer: state, entry bookkeeping, request capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT_FLUSH;
      cmp_eval_reg   <= 1'b0;
      starve_reg     <= '0;
      flush_pend_reg <= 1'b0;
      valid_reg      <= '0;
      cnt_reg        <= '0;
      wr_addr_reg    <= '0;
      wr_key_reg     <= '0;
      wr_dst_reg     <= '0;
      wr_mask_reg    <= '0;
      lkp_id_reg     <= '0;
      res_valid_reg  <= 1'b0;
      res_hit_reg    <= 1'b0;
      res_dst_reg    <= '0;
      res_addr_reg   <= '0;
    end else begin
      // Pulses are remembered until a flush cycle consumes them
      if (bus.flush_req) begin
        flush_pend_reg <= 1'b1;
      end
      case (state_reg)
        INIT_FLUSH, FLUSH: begin
          valid_reg      <= '0;
          cnt_reg        <= '0;
          flush_pend_reg <= 1'b0;
          starve_reg     <= '0;
          state_reg      <= IDLE;
        end
        IDLE: begin
          if (grant_flush) begin
            state_reg <= FLUSH;
          end else if (grant_wr) begin
            wr_addr_reg <= bus.cfg_addr;
            wr_key_reg  <= bus.cfg_key;
            wr_dst_reg  <= bus.cfg_dst;
            wr_mask_reg <= bus.cfg_mask;
            if (bus.lkp_valid && starve_reg != STV_MAX) begin
              starve_reg <= starve_reg + STV_W'(1);
            end
            state_reg <= WRITE;
          end else if (grant_lkp) begin
            lkp_id_reg   <= bus.lkp_id;
            starve_reg   <= '0;
            cmp_eval_reg <= 1'b0;
            state_reg    <= CMP;
          end
        end
        WRITE: begin
          valid_reg[wr_addr_reg] <= 1'b1;
          if (!valid_reg[wr_addr_reg]) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
          state_reg <= IDLE;
        end
        CMP: begin
          if (!cmp_eval_reg) begin
            cmp_eval_reg <= 1'b1;
          end else begin
            cmp_eval_reg <= 1'b0;
            if (tcam_hit) begin
              res_addr_reg <= enc_addr;
              state_reg    <= RD;
            end else begin
              res_hit_reg   <= 1'b0;
              res_dst_reg   <= '0;
              res_addr_reg  <= '0;
              res_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end
          end
        end
        RD: begin
          res_dst_reg   <= tcam_do[DST_LSB +: ID_W];
          res_hit_reg   <= 1'b1;
          res_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= INIT_FLUSH;
      endcase
    end
  end

  // Macro strobes follow the current state; everything is quiet while in reset
  always_comb begin
    tcam_cs    = 1'b0;
    tcam_flush = 1'b0;
    tcam_wr    = 1'b0;
    tcam_cmp   = 1'b0;
    tcam_rd    = 1'b0;
    tcam_vbe   = 1'b0;
    tcam_vbi   = 1'b0;
    tcam_cbe   = 1'b0;
    tcam_a     = '0;
    tcam_di    = '0;
    tcam_mskb  = '0;
    if (!rst) begin
      case (state_reg)
        INIT_FLUSH, FLUSH: begin
          tcam_cs    = 1'b1;
          tcam_flush = 1'b1;
        end
        WRITE: begin
          tcam_cs   = 1'b1;
          tcam_wr   = 1'b1;
          tcam_vbe  = 1'b1;
          tcam_vbi  = 1'b1;
          tcam_cbe  = 1'b1;
          tcam_a    = wr_addr_reg;
          tcam_di   = pack_word(wr_key_reg, wr_dst_reg);
          tcam_mskb = wr_mask_reg;
        end
        CMP: begin
          if (!cmp_eval_reg) begin
            tcam_cs   = 1'b1;
            tcam_cmp  = 1'b1;
            tcam_di   = pack_word(lkp_id_reg, {ID_W{1'b0}});
            tcam_mskb = KEY_ONLY_MSKB;
          end
        end
        RD: begin
          tcam_cs = 1'b1;
          tcam_rd = 1'b1;
          tcam_a  = res_addr_reg;
        end
        default: ;
      endcase
    end
  end

  assign tcam_dcs     = 1'b0;
  assign entry_cnt    = cnt_reg;
  assign table_full   = (cnt_reg == (ADDR_W + 1)'(WORDS));
  assign bus.res_valid = res_valid_reg;
  assign bus.res_hit   = res_hit_reg;
  assign bus.res_dst   = res_dst_reg;
  assign bus.res_addr  = res_addr_reg;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Scoreboard bench for tcam_lookup_ctrl: stimulus pushes expected results,
// a negedge monitor compares every presented result against the queue head.
module tb_tcam_lookup_ctrl;

  typedef struct {
    logic       hit;
    logic [3:0] dst;
    logic [3:0] addr;
    int         lat;
    int         rds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  entry_cnt;
  logic        table_full;
  logic        tcam_cs, tcam_flush, tcam_wr, tcam_cmp, tcam_rd;
  logic        tcam_vbe, tcam_vbi, tcam_dcs, tcam_cbe;
  logic [7:0]  tcam_di, tcam_mskb, tcam_do;
  logic [3:0]  tcam_a;
  logic        tcam_hit;
  logic [15:0] tcam_hitline;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   rd_cnt = 0;
  logic prev_valid = 1'b0;
  exp_t sb_q[$];
  int   grant_log[$];   // 0 = write grant, 1 = lookup grant

  tcam_lookup_ctrl_if bus ();

  tcam_lookup_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .entry_cnt    (entry_cnt),
    .table_full   (table_full),
    .tcam_cs      (tcam_cs),
    .tcam_flush   (tcam_flush),
    .tcam_wr      (tcam_wr),
    .tcam_cmp     (tcam_cmp),
    .tcam_rd      (tcam_rd),
    .tcam_vbe     (tcam_vbe),
    .tcam_vbi     (tcam_vbi),
    .tcam_dcs     (tcam_dcs),
    .tcam_di      (tcam_di),
    .tcam_mskb    (tcam_mskb),
    .tcam_a       (tcam_a),
    .tcam_cbe     (tcam_cbe),
    .tcam_do      (tcam_do),
    .tcam_hit     (tcam_hit),
    .tcam_hitline (tcam_hitline)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor: latency, stability while stalled, no grants during a result, rd count
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lkp_valid && bus.lkp_ready) begin
        grant_cyc = cyc;
        rd_cnt    = 0;
        grant_log.push_back(1);
      end
      if (bus.cfg_valid && bus.cfg_ready) grant_log.push_back(0);
      if (tcam_rd) rd_cnt++;
      if (bus.res_valid) begin
        chk("no_grant_in_resp", {30'd0, bus.cfg_ready, bus.lkp_ready}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("res_unexpected", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) chk("res_latency", cyc - grant_cyc - 1, sb_q[0].lat);
          chk("res_hit", {31'd0, bus.res_hit}, {31'd0, sb_q[0].hit});
          chk("res_dst", {28'd0, bus.res_dst}, {28'd0, sb_q[0].dst});
          chk("res_addr", {28'd0, bus.res_addr}, {28'd0, sb_q[0].addr});
          if (bus.res_ready) begin
            chk("rd_pulses", rd_cnt, sb_q[0].rds);
            void'(sb_q.pop_front());
          end
        end
      end
    end
    prev_valid = bus.res_valid;
  end

  task automatic push_exp(input logic hit, input logic [3:0] dst, input logic [3:0] addr,
                          input int lat, input int rds);
    exp_t e;
    e.hit = hit; e.dst = dst; e.addr = addr; e.lat = lat; e.rds = rds;
    sb_q.push_back(e);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] k, input logic [3:0] d,
                          input logic [7:0] m);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_addr = a; bus.cfg_key = k; bus.cfg_dst = d; bus.cfg_mask = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("cfg_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("wr_strobe", {29'd0, tcam_cs, tcam_wr, tcam_cbe}, 32'd7);
    chk("wr_addr", {28'd0, tcam_a}, {28'd0, a});
    chk("wr_di", {24'd0, tcam_di}, {24'd0, k, d});
    chk("wr_mskb", {24'd0, tcam_mskb}, {24'd0, m});
  endtask

  task automatic do_lookup(input logic [3:0] id, input bit pulse_flush);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.lkp_valid = 1'b1; bus.lkp_id = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.lkp_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("lkp_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.lkp_valid = 1'b0;
    if (pulse_flush) bus.flush_req = 1'b1;
    @(negedge clk);
    chk("cmp_strobe", {30'd0, tcam_cs, tcam_cmp}, 32'd3);
    chk("cmp_di", {24'd0, tcam_di}, {24'd0, id, 4'h0});
    chk("cmp_mskb", {24'd0, tcam_mskb}, 32'hF0);
    if (pulse_flush) begin
      @(posedge clk); #1;
      bus.flush_req = 1'b0;
    end
  endtask

  task automatic wait_res_valid();
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin got = 1'b1; break; end
    end
    if (!got) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int exp_cnt;
    int k;
    bit got;
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_key = '0; bus.cfg_dst = '0;
    bus.cfg_mask = '0; bus.flush_req = 1'b0; bus.lkp_valid = 1'b0; bus.lkp_id = '0;
    bus.res_ready = 1'b1;
    tcam_do = '0; tcam_hit = 1'b0; tcam_hitline = '0;

    // Reset, init flush, then an immediate miss lookup for id 7
    bus.lkp_valid = 1'b1; bus.lkp_id = 4'h7;
    push_exp(1'b0, 4'h0, 4'h0, 2, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {27'd0, bus.res_valid, bus.cfg_ready, bus.lkp_ready, tcam_flush, tcam_cs}, 32'd0);
    chk("rst_entry_cnt", {27'd0, entry_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("init_flush", {31'd0, tcam_flush}, 32'd1);
    chk("init_lkp_ready", {31'd0, bus.lkp_ready}, 32'd0);
    @(negedge clk);
    chk("post_init_flush", {31'd0, tcam_flush}, 32'd0);
    chk("post_init_lkp_ready", {31'd0, bus.lkp_ready}, 32'd1);
    chk("post_init_cnt", {27'd0, entry_cnt}, 32'd0);
    @(posedge clk); #1;
    bus.lkp_valid = 1'b0;
    @(negedge clk);
    chk("miss_cmp_di", {24'd0, tcam_di}, 32'h70);
    wait_drain();

    // Rewrite of an entry does not count twice; flush pulsed during CMP
    do_write(4'h2, 4'h1, 4'h1, 8'hF0);
    do_write(4'h2, 4'h1, 4'h2, 8'hF0);
    do_write(4'h5, 4'h3, 4'hC, 8'hF0);
    @(negedge clk);
    chk("cnt_after_rewrite", {27'd0, entry_cnt}, 32'd2);
    tcam_hit = 1'b1; tcam_hitline = 16'h0110; tcam_do = 8'h3C;
    push_exp(1'b1, 4'hC, 4'h4, 3, 1);
    do_lookup(4'h3, 1'b1);
    @(negedge clk);
    wait_res_valid();
    chk("cnt_before_flush", {27'd0, entry_cnt}, 32'd2);
    k = 0; got = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (tcam_flush) begin k = i; got = 1'b1; break; end
    end
    chk("flush_after_resp", k, 2);
    @(negedge clk);
    chk("cnt_after_flush", {27'd0, entry_cnt}, 32'd0);
    wait_drain();

    // Hit at entry 3 with the result stalled; a pending write must not be granted
    do_write(4'h3, 4'hA, 4'h5, 8'hF0);
    @(negedge clk);
    chk("cnt_one", {27'd0, entry_cnt}, 32'd1);
    bus.res_ready = 1'b0;
    tcam_hit = 1'b1; tcam_hitline = 16'h0008; tcam_do = 8'hA5;
    push_exp(1'b1, 4'h5, 4'h3, 3, 1);
    do_lookup(4'hA, 1'b0);
    bus.cfg_valid = 1'b1; bus.cfg_addr = 4'h9;
    wait_res_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("resp_quiet_strobes", {30'd0, tcam_cs, tcam_rd}, 32'd0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1; bus.cfg_valid = 1'b0;
    wait_drain();

    // Fill every entry (address 3 is a rewrite) up to table_full
    exp_cnt = 1;
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), 4'(a), 4'(15 - a), 8'hFF);
      if (a != 3) exp_cnt++;
      @(negedge clk);
      chk("fill_cnt", {27'd0, entry_cnt}, exp_cnt);
      chk("fill_full", {31'd0, table_full}, {31'd0, exp_cnt == 16});
    end

    // Both requesters held: four writes, then one lookup, repeating
    grant_log.delete();
    tcam_hit = 1'b0; tcam_hitline = '0; tcam_do = '0;
    push_exp(1'b0, 4'h0, 4'h0, 2, 0);
    push_exp(1'b0, 4'h0, 4'h0, 2, 0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_addr = 4'h0; bus.cfg_key = 4'h1; bus.cfg_dst = 4'h1;
    bus.cfg_mask = 8'hF0; bus.lkp_valid = 1'b1; bus.lkp_id = 4'h7;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= 10) begin got = 1'b1; break; end
    end
    bus.cfg_valid = 1'b0; bus.lkp_valid = 1'b0;
    if (!got) chk("starve_timeout", grant_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) chk($sformatf("grant_seq_%0d", i), grant_log[i], (i % 5 == 4) ? 1 : 0);
    end
    wait_drain();

    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
